// File: rtl/cipher_pkg.sv
// Shared constants and types for the cipher dispatch front end.
// Channel indices, serializer states and the word-to-byte ratio helper.
package cipher_pkg;

  localparam int CH_CAESAR  = 0;
  localparam int CH_SCYTALE = 1;
  localparam int CH_ZIGZAG  = 2;

  typedef enum logic {
    IDLE,
    SHIFT
  } ser_state_t;

  function automatic int cipher_bytes(
    input int mst_w,
    input int sys_w
  );
    return mst_w / sys_w;
  endfunction

endpackage

// File: rtl/cipher_fifo.sv
// Synchronous FIFO holding tagged ciphertext words.
// Full/empty come from a registered occupancy counter.
module cipher_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wptr] <= i_wdata;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (i_pop) r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(i_pop);
    end
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/cipher_dispatch.sv
// Buffered word-to-byte dispatcher feeding NUM_CH decryption engines.
// Optional byte counter enabled by CIPHER_DISPATCH_STATS_EN.
module cipher_dispatch
  import cipher_pkg::*;
#(
  parameter int MST_DWIDTH = 32,
  parameter int SYS_DWIDTH = 8,
  parameter int NUM_CH     = 3,
  parameter int DEPTH      = 4,
  parameter int SEL_W      = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [SEL_W-1:0]             sel,
  input  logic [MST_DWIDTH-1:0]        data_i,
  input  logic                         valid_i,
  output logic                         busy,
  input  logic                         clr_i,
  output logic [NUM_CH*SYS_DWIDTH-1:0] ch_data_o,
  output logic [NUM_CH-1:0]            ch_valid_o,
  input  logic [NUM_CH-1:0]            ch_busy_i,
  input  logic [NUM_CH*SYS_DWIDTH-1:0] ch_data_i,
  input  logic [NUM_CH-1:0]            ch_valid_i,
  output logic [SYS_DWIDTH-1:0]        data_o,
  output logic                         valid_o,
  output logic                         sel_err,
  output logic                         ovf
`ifdef CIPHER_DISPATCH_STATS_EN
  ,
  output logic [15:0]                  byte_cnt
`endif
);

  localparam int BYTES = cipher_bytes(MST_DWIDTH, SYS_DWIDTH);
  localparam int CW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int FW    = MST_DWIDTH + SEL_W;
  localparam logic [SEL_W:0] NCH = (SEL_W+1)'(NUM_CH);

  ser_state_t r_state;
  ser_state_t w_state_nxt;

  logic [MST_DWIDTH-1:0]        r_sr;
  logic [CW-1:0]                r_cnt;
  logic [SEL_W-1:0]             r_act_ch;
  logic [NUM_CH-1:0]            r_ch_valid;
  logic [NUM_CH*SYS_DWIDTH-1:0] r_ch_data;
  logic [SYS_DWIDTH-1:0]        r_data_o;
  logic                         r_valid_o;
  logic                         r_sel_err;
  logic                         r_ovf;

  logic          w_sel_ok;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_issue;
  logic          w_ch_busy;
  logic [FW-1:0] w_rdata;

  assign w_sel_ok  = ({1'b0, sel} < NCH);
  assign w_push    = valid_i && !w_full && w_sel_ok;
  assign w_ch_busy = ch_busy_i[r_act_ch];

  cipher_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata ({sel, data_i}),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Last byte and next pop share a cycle so words run back-to-back.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_issue     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (!w_ch_busy) begin
          w_issue = 1'b1;
          if (r_cnt == '0) begin
            if (!w_empty) w_pop = 1'b1;
            else          w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr       <= '0;
      r_cnt      <= '0;
      r_act_ch   <= '0;
      r_ch_valid <= '0;
      r_ch_data  <= '0;
      r_data_o   <= '0;
      r_valid_o  <= 1'b0;
      r_sel_err  <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_ch_valid <= '0;
      r_ch_data  <= '0;
      if (w_issue) begin
        r_ch_valid[r_act_ch] <= 1'b1;
        r_ch_data[int'(r_act_ch)*SYS_DWIDTH +: SYS_DWIDTH] <=
          r_sr[MST_DWIDTH-1 -: SYS_DWIDTH];
        r_sr  <= r_sr << SYS_DWIDTH;
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_pop) begin
        r_sr     <= w_rdata[MST_DWIDTH-1:0];
        r_act_ch <= w_rdata[FW-1 -: SEL_W];
        r_cnt    <= CW'(BYTES-1);
      end
      r_data_o  <= ch_data_i[int'(r_act_ch)*SYS_DWIDTH +: SYS_DWIDTH];
      r_valid_o <= ch_valid_i[r_act_ch];
      r_sel_err <= (valid_i && !w_sel_ok) || (r_sel_err && !clr_i);
      r_ovf     <= (valid_i && w_full) || (r_ovf && !clr_i);
    end
  end

`ifdef CIPHER_DISPATCH_STATS_EN
  logic [15:0] r_byte_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             r_byte_cnt <= '0;
    else if (clr_i)                         r_byte_cnt <= '0;
    else if (w_issue && r_byte_cnt != '1)   r_byte_cnt <= r_byte_cnt + 16'd1;
  end

  assign byte_cnt = r_byte_cnt;
`endif

  assign busy       = w_full;
  assign ch_valid_o = r_ch_valid;
  assign ch_data_o  = r_ch_data;
  assign data_o     = r_data_o;
  assign valid_o    = r_valid_o;
  assign sel_err    = r_sel_err;
  assign ovf        = r_ovf;

endmodule

// File: tb/tb_cipher_dispatch.sv
// Self-checking bench for cipher_dispatch: directed tables and sequences
// plus randomized traffic against a queue-based reference model.
module tb_cipher_dispatch;
  import cipher_pkg::*;

  localparam int MW   = 32;
  localparam int SW   = 8;
  localparam int NCH  = 3;
  localparam int DEP  = 4;
  localparam int SELW = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [SELW-1:0]   sel;
  logic [MW-1:0]     data_i;
  logic              valid_i;
  logic              busy;
  logic              clr_i;
  logic [NCH*SW-1:0] ch_data_o;
  logic [NCH-1:0]    ch_valid_o;
  logic [NCH-1:0]    ch_busy_i;
  logic [NCH*SW-1:0] ch_data_i;
  logic [NCH-1:0]    ch_valid_i;
  logic [SW-1:0]     data_o;
  logic              valid_o;
  logic              sel_err;
  logic              ovf;
`ifdef CIPHER_DISPATCH_STATS_EN
  logic [15:0]       byte_cnt;
`endif

  always #5 clk = ~clk;

  cipher_dispatch #(
    .MST_DWIDTH (MW),
    .SYS_DWIDTH (SW),
    .NUM_CH     (NCH),
    .DEPTH      (DEP),
    .SEL_W      (SELW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sel        (sel),
    .data_i     (data_i),
    .valid_i    (valid_i),
    .busy       (busy),
    .clr_i      (clr_i),
    .ch_data_o  (ch_data_o),
    .ch_valid_o (ch_valid_o),
    .ch_busy_i  (ch_busy_i),
    .ch_data_i  (ch_data_i),
    .ch_valid_i (ch_valid_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .sel_err    (sel_err),
    .ovf        (ovf)
`ifdef CIPHER_DISPATCH_STATS_EN
    ,
    .byte_cnt   (byte_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pending words, bytes left of the active word
  logic [MW-1:0]     mq_w [$];
  int                mq_c [$];
  logic [SW-1:0]     cb [$];
  int                m_ch;
  logic              e_busy;
  logic [NCH-1:0]    e_chv;
  logic [NCH*SW-1:0] e_chd;
  logic [SW-1:0]     e_do;
  logic              e_vo;
  logic              e_se;
  logic              e_ov;
  int                e_bc;

  function automatic void model_reset();
    mq_w.delete();
    mq_c.delete();
    cb.delete();
    m_ch   = 0;
    e_busy = 1'b0;
    e_chv  = '0;
    e_chd  = '0;
    e_do   = '0;
    e_vo   = 1'b0;
    e_se   = 1'b0;
    e_ov   = 1'b0;
    e_bc   = 0;
  endfunction

  function automatic void model_load();
    logic [MW-1:0] w;
    w    = mq_w.pop_front();
    m_ch = mq_c.pop_front();
    for (int b = 0; b < MW/SW; b++) cb.push_back(w[MW-1-b*SW -: SW]);
  endfunction

  function automatic void model_edge();
    bit full, had, ok, psh, iss;
    full = (mq_w.size() == DEP);
    had  = (mq_w.size() != 0);
    ok   = (int'(sel) < NCH);
    psh  = valid_i && !full && ok;
    iss  = 1'b0;
    e_se = (valid_i && !ok) || (e_se && !clr_i);
    e_ov = (valid_i && full) || (e_ov && !clr_i);
    e_do = ch_data_i[m_ch*SW +: SW];
    e_vo = ch_valid_i[m_ch];
    e_chv = '0;
    e_chd = '0;
    if (cb.size() != 0) begin
      if (!ch_busy_i[m_ch]) begin
        iss = 1'b1;
        e_chv[m_ch] = 1'b1;
        e_chd[m_ch*SW +: SW] = cb.pop_front();
        if (cb.size() == 0 && had) model_load();
      end
    end else if (had) begin
      model_load();
    end
    if (psh) begin
      mq_w.push_back(data_i);
      mq_c.push_back(int'(sel));
    end
    e_busy = (mq_w.size() == DEP);
    if (clr_i)                  e_bc = 0;
    else if (iss && e_bc < 65535) e_bc++;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("busy", 64'(busy), 64'(e_busy));
    chk("ch_valid_o", 64'(ch_valid_o), 64'(e_chv));
    chk("ch_data_o", 64'(ch_data_o), 64'(e_chd));
    chk("data_o", 64'(data_o), 64'(e_do));
    chk("valid_o", 64'(valid_o), 64'(e_vo));
    chk("sel_err", 64'(sel_err), 64'(e_se));
    chk("ovf", 64'(ovf), 64'(e_ov));
`ifdef CIPHER_DISPATCH_STATS_EN
    chk("byte_cnt", 64'(byte_cnt), 64'(e_bc));
`endif
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle_in();
    valid_i    = 1'b0;
    sel        = '0;
    data_i     = '0;
    clr_i      = 1'b0;
    ch_busy_i  = '0;
    ch_data_i  = '0;
    ch_valid_i = '0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_chv"}, 64'(ch_valid_o), 64'd0);
    chk({tag, "_chd"}, 64'(ch_data_o), 64'd0);
    chk({tag, "_do"}, 64'(data_o), 64'd0);
    chk({tag, "_vo"}, 64'(valid_o), 64'd0);
    chk({tag, "_se"}, 64'(sel_err), 64'd0);
    chk({tag, "_ovf"}, 64'(ovf), 64'd0);
  endtask

  typedef struct {
    logic       v;
    logic [1:0] s;
    logic       clr;
    logic       exp_se;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int nb;
    tbl[0] = '{1'b1, 2'd3, 1'b0, 1'b1};
    tbl[1] = '{1'b0, 2'd0, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 2'd0, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 2'd3, 1'b1, 1'b1};
    tbl[4] = '{1'b0, 2'd0, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 2'd0, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 2'(CH_ZIGZAG), 1'b0, 1'b0};

    idle_in();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;

    // Single word on channel 1: pop, then four bytes MSB first
    valid_i = 1'b1; sel = 2'(CH_SCYTALE); data_i = 32'h11223344;
    cyc();
    valid_i = 1'b0;
    cyc();
    chk("t1_pop_idle", 64'(ch_valid_o), 64'd0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t1_chv", 64'(ch_valid_o), 64'b010);
      chk("t1_chd", 64'(ch_data_o), 64'({8'h00, 8'(8'h11 * (i + 1)), 8'h00}));
    end
    cyc();
    chk("t1_end", 64'(ch_valid_o), 64'd0);

    // Engine 0 stalls for 5 cycles after byte 2
    valid_i = 1'b1; sel = 2'(CH_CAESAR); data_i = 32'hAABBCCDD;
    cyc();
    valid_i = 1'b0;
    cyc();
    cyc(); chk("t2_b1", 64'(ch_data_o), 64'h0000AA);
    cyc(); chk("t2_b2", 64'(ch_data_o), 64'h0000BB);
    ch_busy_i = 3'b001;
    for (int i = 0; i < 5; i++) begin
      cyc(); chk("t2_stall", 64'(ch_valid_o), 64'd0);
    end
    ch_busy_i = '0;
    cyc(); chk("t2_b3", 64'(ch_data_o), 64'h0000CC);
    cyc(); chk("t2_b4", 64'(ch_data_o), 64'h0000DD);
    cyc(); chk("t2_end", 64'(ch_valid_o), 64'd0);

    // Overflow with all engines busy; one word sits in the serializer
    ch_busy_i = '1;
    for (int i = 0; i < 6; i++) begin
      valid_i = 1'b1; sel = 2'(i % 3); data_i = 32'h0101_0101 * (i + 1);
      cyc();
    end
    valid_i = 1'b0;
    cyc();
    chk("t3_busy", 64'(busy), 64'd1);
    chk("t3_ovf", 64'(ovf), 64'd1);
    ch_busy_i = '0;
    nb = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (ch_valid_o != '0) nb++;
    end
    chk("t3_drained_bytes", 64'(nb), 64'd20);
    chk("t3_busy_off", 64'(busy), 64'd0);
    clr_i = 1'b1;
    cyc();
    clr_i = 1'b0;
    chk("t3_ovf_clr", 64'(ovf), 64'd0);

    // sel_err sticky / clear / set-wins table
    for (int i = 0; i < 7; i++) begin
      valid_i = tbl[i].v; sel = tbl[i].s; clr_i = tbl[i].clr;
      data_i = $urandom;
      cyc();
      chk($sformatf("tbl_sel_err[%0d]", i), 64'(sel_err), 64'(tbl[i].exp_se));
    end
    idle_in();
    repeat (8) cyc();

    // Merge: only the active channel's result passes
    valid_i = 1'b1; sel = 2'(CH_ZIGZAG); data_i = 32'hCAFE0001;
    cyc();
    valid_i = 1'b0;
    cyc();
    ch_valid_i = 3'b101; ch_data_i = {8'h5C, 8'h00, 8'hAA};
    cyc();
    chk("t5_do", 64'(data_o), 64'h5C);
    chk("t5_vo", 64'(valid_o), 64'd1);
    ch_valid_i = 3'b001; ch_data_i = {8'h00, 8'h00, 8'h77};
    cyc();
    chk("t5_vo_ignored", 64'(valid_o), 64'd0);
    idle_in();
    repeat (6) cyc();

    // Reset during byte 2
    valid_i = 1'b1; sel = 2'(CH_SCYTALE); data_i = 32'h12345678;
    cyc();
    valid_i = 1'b0;
    cyc();
    cyc();
    cyc(); chk("t6_b2", 64'(ch_data_o), 64'h003400);
    rst_n = 1'b0;
    #1;
    chk_zero("t6_rst");
    model_reset();
    idle_in();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    valid_i = 1'b1; sel = 2'(CH_CAESAR); data_i = 32'h9ABCDEF0;
    cyc();
    valid_i = 1'b0;
    cyc();
    cyc();
    chk("t6_first_chv", 64'(ch_valid_o), 64'b001);
    chk("t6_first_chd", 64'(ch_data_o), 64'h00009A);
    repeat (6) cyc();

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      valid_i    = ($urandom_range(0, 1) == 1);
      sel        = 2'($urandom_range(0, 3));
      data_i     = $urandom;
      clr_i      = ($urandom_range(0, 15) == 0);
      ch_busy_i  = '0;
      for (int k = 0; k < NCH; k++) ch_busy_i[k] = ($urandom_range(0, 3) == 0);
      ch_valid_i = 3'($urandom);
      ch_data_i  = 24'($urandom);
      cyc();
    end
    idle_in();
    repeat (30) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
